// File: rtl/store_commit_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_commit_buffer
//  Description : Post-commit store buffer. Accepts up to COMMIT_W committed
//                stores per cycle into a circular FIFO, drains one store per
//                cycle to data memory, and forwards the youngest matching
//                buffered word to loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_commit_buffer #(
  parameter int COMMIT_W = 2,   // matches core issue width
  parameter int XLEN     = 32,
  parameter int DEPTH    = 8    // power of two, >= COMMIT_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [COMMIT_W-1:0]     st_commit_valid,
  input  logic [XLEN-1:0]         st_commit_addr [COMMIT_W],
  input  logic [XLEN-1:0]         st_commit_data [COMMIT_W],
  input  logic [XLEN/8-1:0]       st_commit_be   [COMMIT_W],
  output logic                    st_commit_ready,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [XLEN-1:0]         mem_req_addr,
  output logic [XLEN-1:0]         mem_req_data,
  output logic [XLEN/8-1:0]       mem_req_be,
  input  logic [XLEN-1:0]         ld_fwd_addr,
  output logic                    ld_fwd_hit,
  output logic [XLEN-1:0]         ld_fwd_data,
  output logic [XLEN/8-1:0]       ld_fwd_be,
  output logic [$clog2(DEPTH):0]  sb_count,
  output logic                    sb_empty,
  output logic                    sb_full,
  output logic                    overflow_err,
  output logic [31:0]             perf_stores_drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = XLEN / 8;
  localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_commit_w = (AW+1)'(COMMIT_W);
  localparam logic [AW:0]   c_one_cnt  = (AW+1)'(1);
  localparam logic [AW-1:0] c_one_ptr  = AW'(1);

  // Entry storage (not reset) and occupancy state
  logic [XLEN-1:0] r_addr [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [BW-1:0]   r_be   [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW:0]     r_count;
  logic            r_overflow;
  logic [31:0]     r_drained;

  logic [AW:0]     w_lane_off [COMMIT_W];
  logic [AW-1:0]   w_slot     [COMMIT_W];
  logic [AW:0]     w_n_enq;
  logic [AW:0]     w_n_acc;
  logic            w_pop;
  logic [AW-1:0]   w_fwd_idx;
  logic            w_unused_bits;

  // Status and head presentation straight from registered state
  assign sb_count            = r_count;
  assign sb_empty            = (r_count == '0);
  assign sb_full             = (r_count == c_depth);
  assign st_commit_ready     = ((c_depth - r_count) >= c_commit_w);
  assign mem_req_valid       = !sb_empty;
  assign mem_req_addr        = r_addr[r_head];
  assign mem_req_data        = r_data[r_head];
  assign mem_req_be          = r_be[r_head];
  assign overflow_err        = r_overflow;
  assign perf_stores_drained = r_drained;
  assign w_pop               = mem_req_valid && mem_req_ready;
  assign w_n_acc             = st_commit_ready ? w_n_enq : '0;
  assign w_unused_bits       = ^ld_fwd_addr[1:0];

  // Compact valid lanes: each valid lane takes the next slot after the tail
  always_comb begin
    w_n_enq = '0;
    for (int l = 0; l < COMMIT_W; l++) begin
      w_lane_off[l] = w_n_enq;
      w_slot[l]     = r_tail + w_lane_off[l][AW-1:0];
      if (st_commit_valid[l]) w_n_enq = w_n_enq + c_one_cnt;
    end
  end

  // Write accepted lanes into their compacted slots
  always_ff @(posedge clk) begin
    for (int l = 0; l < COMMIT_W; l++) begin
      if (st_commit_ready && st_commit_valid[l]) begin
        r_addr[w_slot[l]] <= st_commit_addr[l];
        r_data[w_slot[l]] <= st_commit_data[l];
        r_be[w_slot[l]]   <= st_commit_be[l];
      end
    end
  end

  // Pointers, occupancy, sticky overflow and drain counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_valid    <= '0;
      r_overflow <= 1'b0;
      r_drained  <= '0;
    end else begin
      // The popped slot is never one being filled: a full buffer refuses stores
      if (w_pop) begin
        r_head          <= r_head + c_one_ptr;
        r_valid[r_head] <= 1'b0;
        r_drained       <= r_drained + 32'd1;
      end
      if (st_commit_ready) begin
        for (int l = 0; l < COMMIT_W; l++) begin
          if (st_commit_valid[l]) r_valid[w_slot[l]] <= 1'b1;
        end
      end else if (|st_commit_valid) begin
        r_overflow <= 1'b1;
      end
      r_tail  <= r_tail + w_n_acc[AW-1:0];
      r_count <= r_count + w_n_acc - {{AW{1'b0}}, w_pop};
    end
  end

  // Forwarding: walk entries oldest to youngest so the last match wins
  always_comb begin
    ld_fwd_hit  = 1'b0;
    ld_fwd_data = '0;
    ld_fwd_be   = '0;
    w_fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fwd_idx = r_head + AW'(i);
      if (r_valid[w_fwd_idx] &&
          (r_addr[w_fwd_idx][XLEN-1:2] == ld_fwd_addr[XLEN-1:2])) begin
        ld_fwd_hit  = 1'b1;
        ld_fwd_data = r_data[w_fwd_idx];
        ld_fwd_be   = r_be[w_fwd_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_commit_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_commit_buffer
//  Description : Self-checking bench for store_commit_buffer. A queue-based
//                reference model tracks buffered stores, drains and the
//                sticky overflow flag; directed scenarios plus random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_commit_buffer;

  localparam int CW    = 2;
  localparam int XL    = 32;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [CW-1:0] st_commit_valid;
  logic [XL-1:0] st_commit_addr [CW];
  logic [XL-1:0] st_commit_data [CW];
  logic [3:0]    st_commit_be   [CW];
  logic        st_commit_ready;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_be;
  logic [31:0] ld_fwd_addr;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic [3:0]  ld_fwd_be;
  logic [3:0]  sb_count;
  logic        sb_empty;
  logic        sb_full;
  logic        overflow_err;
  logic [31:0] perf_stores_drained;

  store_commit_buffer #(.COMMIT_W(CW), .XLEN(XL), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .st_commit_valid     (st_commit_valid),
    .st_commit_addr      (st_commit_addr),
    .st_commit_data      (st_commit_data),
    .st_commit_be        (st_commit_be),
    .st_commit_ready     (st_commit_ready),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_addr        (mem_req_addr),
    .mem_req_data        (mem_req_data),
    .mem_req_be          (mem_req_be),
    .ld_fwd_addr         (ld_fwd_addr),
    .ld_fwd_hit          (ld_fwd_hit),
    .ld_fwd_data         (ld_fwd_data),
    .ld_fwd_be           (ld_fwd_be),
    .sb_count            (sb_count),
    .sb_empty            (sb_empty),
    .sb_full             (sb_full),
    .overflow_err        (overflow_err),
    .perf_stores_drained (perf_stores_drained)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t        q[$];
  logic        m_ovf;
  logic [31:0] m_drained;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Compare every observable output with the model's view of the buffer
  task automatic compare_all();
    logic        hit;
    logic [31:0] fd;
    logic [3:0]  fb;
    int          sz;
    hit = 1'b0; fd = '0; fb = '0;
    sz  = q.size();
    chk("count",    32'(sb_count),        32'(sz));
    chk("empty",    32'(sb_empty),        32'(sz == 0));
    chk("full",     32'(sb_full),         32'(sz == DEPTH));
    chk("ready",    32'(st_commit_ready), 32'((DEPTH - sz) >= CW));
    chk("memvalid", 32'(mem_req_valid),   32'(sz != 0));
    if (sz != 0) begin
      chk("head_addr", mem_req_addr,      q[0].addr);
      chk("head_data", mem_req_data,      q[0].data);
      chk("head_be",   32'(mem_req_be),   32'(q[0].be));
    end
    chk("overflow", 32'(overflow_err), 32'(m_ovf));
    chk("perf",     perf_stores_drained, m_drained);
    for (int i = 0; i < sz; i++) begin
      if (q[i].addr[31:2] == ld_fwd_addr[31:2]) begin
        hit = 1'b1; fd = q[i].data; fb = q[i].be;
      end
    end
    chk("fwd_hit", 32'(ld_fwd_hit), 32'(hit));
    if (hit) begin
      chk("fwd_data", ld_fwd_data,     fd);
      chk("fwd_be",   32'(ld_fwd_be),  32'(fb));
    end
  endtask

  // One cycle: drive at negedge, check, then advance the model for the posedge
  task automatic step(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [3:0] b0, input logic [3:0] b1,
                      input logic mr, input logic [31:0] la);
    bit rdy;
    @(negedge clk);
    st_commit_valid   = v;
    st_commit_addr[0] = a0; st_commit_addr[1] = a1;
    st_commit_data[0] = d0; st_commit_data[1] = d1;
    st_commit_be[0]   = b0; st_commit_be[1]   = b1;
    mem_req_ready     = mr;
    ld_fwd_addr       = la;
    #1;
    compare_all();
    rdy = ((DEPTH - q.size()) >= CW);
    if (q.size() != 0 && mr) begin
      void'(q.pop_front());
      m_drained++;
    end
    if (rdy) begin
      if (v[0]) q.push_back(ent_t'{addr: a0, data: d0, be: b0});
      if (v[1]) q.push_back(ent_t'{addr: a1, data: d1, be: b1});
    end else if (v != 2'b00) begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic idle(input logic mr, input logic [31:0] la);
    step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, mr, la);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h300 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
  endfunction

  task automatic rand_step(input int mr_pct);
    step(2'($urandom_range(0, 3)), rand_addr(), rand_addr(), $urandom, $urandom,
         4'($urandom), 4'($urandom), ($urandom_range(0, 99) < mr_pct), rand_addr());
  endtask

  // Assert reset between clock edges and check it takes effect at once
  task automatic async_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_memvalid_now", 32'(mem_req_valid), 32'd0);
    q.delete();
    m_ovf     = 1'b0;
    m_drained = '0;
    compare_all();
    @(negedge clk);
    st_commit_valid = '0;
    mem_req_ready   = 1'b0;
    reset_n         = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    n_checks = 0; n_fail = 0;
    m_ovf = 1'b0; m_drained = '0;
    reset_n = 1'b0;
    st_commit_valid = '0;
    for (int l = 0; l < CW; l++) begin
      st_commit_addr[l] = '0; st_commit_data[l] = '0; st_commit_be[l] = '0;
    end
    mem_req_ready = 1'b0;
    ld_fwd_addr   = '0;
    @(negedge clk);
    #1;
    compare_all();
    chk("rst_ready", 32'(st_commit_ready), 32'd1);
    reset_n = 1'b1;

    // Two-lane enqueue, memory stalled
    step(2'b11, 32'h100, 32'h104, 32'h11, 32'h22, 4'hF, 4'hF, 1'b0, 32'h0);
    idle(1'b0, 32'h0);
    chk("two_lane_count", 32'(sb_count), 32'd2);
    chk("two_lane_head",  mem_req_addr,  32'h100);
    chk("two_lane_valid", 32'(mem_req_valid), 32'd1);

    // Fill to seven, then a store with no room is dropped
    step(2'b11, 32'h108, 32'h10C, 32'h33, 32'h44, 4'hF, 4'hF, 1'b0, 32'h0);
    step(2'b11, 32'h110, 32'h114, 32'h55, 32'h66, 4'hF, 4'hF, 1'b0, 32'h0);
    step(2'b01, 32'h118, 32'h0,   32'h77, 32'h0,  4'hF, 4'h0, 1'b0, 32'h0);
    step(2'b01, 32'h11C, 32'h0,   32'h88, 32'h0,  4'hF, 4'h0, 1'b0, 32'h0);
    chk("seven_not_ready", 32'(st_commit_ready), 32'd0);
    idle(1'b0, 32'h0);
    chk("drop_overflow", 32'(overflow_err), 32'd1);
    chk("drop_count",    32'(sb_count),     32'd7);
    repeat (7) idle(1'b1, 32'h110);
    idle(1'b0, 32'h0);
    chk("drained_empty", 32'(sb_empty), 32'd1);

    // Youngest matching word wins, with its own byte enables only
    step(2'b11, 32'h200, 32'h202, 32'hAAAA_AAAA, 32'h0000_BB00, 4'hF, 4'h4, 1'b0, 32'h200);
    idle(1'b0, 32'h200);
    chk("fwd_young_hit",  32'(ld_fwd_hit), 32'd1);
    chk("fwd_young_data", ld_fwd_data,     32'h0000_BB00);
    chk("fwd_young_be",   32'(ld_fwd_be),  32'h4);
    idle(1'b0, 32'h204);
    idle(1'b1, 32'h200);
    idle(1'b1, 32'h203);
    idle(1'b0, 32'h200);

    // Streaming one store per cycle while draining: pointers wrap
    base = int'(m_drained);
    for (int i = 0; i < 20; i++)
      step(2'b01, 32'h1000 + 32'(i) * 4, 32'h0, 32'hC000_0000 + 32'(i), 32'h0,
           4'($urandom), 4'h0, 1'b1, 32'h1000 + 32'(i) * 4);
    idle(1'b0, 32'h0);
    chk("stream_perf",  perf_stores_drained, 32'(base + 19));
    chk("stream_count", 32'(sb_count),       32'd1);

    // Upper lane only, with a pop in the same cycle at count three
    step(2'b11, 32'h300, 32'h304, 32'h30, 32'h34, 4'hF, 4'hF, 1'b0, 32'h0);
    step(2'b10, 32'hDEAD_0000, 32'h444, 32'hDEAD_BEEF, 32'h39, 4'h1, 4'h3, 1'b1, 32'h444);
    idle(1'b0, 32'h444);
    chk("lane1_count", 32'(sb_count), 32'd3);
    idle(1'b1, 32'h0);
    idle(1'b1, 32'h0);
    idle(1'b0, 32'h0);
    chk("lane1_addr", mem_req_addr, 32'h444);
    chk("lane1_data", mem_req_data, 32'h39);
    idle(1'b1, 32'h0);

    // Random traffic under varying memory back-pressure
    for (int ph = 0; ph < 8; ph++) begin
      for (int c = 0; c < 250; c++) rand_step((ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 55 : 90));
    end

    // Reset while stalled with five stores pending
    repeat (DEPTH + 1) idle(1'b1, 32'h0);
    step(2'b11, 32'h500, 32'h504, 32'h1, 32'h2, 4'hF, 4'hF, 1'b0, 32'h0);
    step(2'b11, 32'h508, 32'h50C, 32'h3, 32'h4, 4'hF, 4'hF, 1'b0, 32'h0);
    step(2'b01, 32'h510, 32'h0,   32'h5, 32'h0, 4'hF, 4'h0, 1'b0, 32'h0);
    idle(1'b0, 32'h500);
    chk("pre_reset_count", 32'(sb_count), 32'd5);
    async_reset();
    idle(1'b0, 32'h500);
    chk("post_reset_empty", 32'(sb_empty), 32'd1);
    chk("post_reset_perf",  perf_stores_drained, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
